// File: rtl/stage0_pkg.sv
// Shared definitions for the stage-0 fetch/branch sequencer: flow-control
// opcodes, branch condition codes, sequencer states and the branch test.
package stage0_pkg;

  // Flow-control opcodes (top five bits of the instruction word)
  localparam logic [4:0] OP_BRA  = 5'b00110;
  localparam logic [4:0] OP_JMP  = 5'b00111;
  localparam logic [4:0] OP_BSR  = 5'b10101;
  localparam logic [4:0] OP_RTS  = 5'b01000;
  localparam logic [4:0] OP_RTI  = 5'b01001;
  localparam logic [4:0] OP_LMSK = 5'b01110;

  // Branch condition codes (low three bits of a BRA)
  localparam logic [2:0] CC_Z  = 3'b000;
  localparam logic [2:0] CC_NZ = 3'b001;
  localparam logic [2:0] CC_N  = 3'b010;
  localparam logic [2:0] CC_NN = 3'b011;
  localparam logic [2:0] CC_C  = 3'b100;
  localparam logic [2:0] CC_NC = 3'b101;
  localparam logic [2:0] CC_V  = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_OPER,
    ST_ISSUE,
    ST_BR_EVAL,
    ST_CALL,
    ST_RET,
    ST_LMSK
  } state_e;

  // Evaluate a branch condition against the stage-1 flags {V,C,N,Z}
  function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] flags);
    logic z, n, c, v;
    logic result;
    v = flags[3];
    c = flags[2];
    n = flags[1];
    z = flags[0];
    case (cond)
      CC_Z:    result = z;
      CC_NZ:   result = ~z;
      CC_N:    result = n;
      CC_NN:   result = ~n;
      CC_C:    result = c;
      CC_NC:   result = ~c;
      CC_V:    result = v;
      CC_AL:   result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/stage0_seq_ret_stack.sv
// Hardware return-address stack. Pushes while full and pops while empty are
// ignored here; the sequencer raises its sticky error flags for those cases.
module ret_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   sp_q, sp_d;
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW-1:0] top_idx;

  assign full    = (sp_q == (PW+1)'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q[PW-1:0] - PW'(1);
  assign top     = mem_q[top_idx];

  // Next stack contents and pointer; writes land at the slot above the top
  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (push && !full) begin
      mem_d[sp_q[PW-1:0]] = din;
      sp_d                = sp_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - (PW+1)'(1);
    end
  end

  // Stack pointer and storage registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sp_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

  // The sequencer never pushes and pops in the same cycle
  no_push_and_pop: assert property (@(posedge clk) disable iff (!clr) !(push && pop));

endmodule

// File: rtl/stage0_seq.sv
// Stage-0 fetch/branch sequencer. Owns the PC, fetches instructions, executes
// flow control (BRA, JMP, BSR, RTS, RTI, LMSK) locally and hands every other
// instruction to stage 1 over a valid/ready handshake. Handles interrupt entry
// with a nesting lockout and keeps return addresses on a small hardware stack.
module stage0_seq
  import stage0_pkg::*;
#(
  parameter int            AW        = 8,
  parameter int            IW        = 8,
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter logic [AW-1:0] IRQ_VEC   = 'hF0,
  parameter int            MW        = 3
) (
  input  logic          clk,
  input  logic          clr,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic [3:0]    flags,
  input  logic          i_pending,
  output logic          i_ack,
  output logic          stg0_valid,
  output logic [IW-1:0] stg0_instr,
  input  logic          stg1_ready,
  output logic          mask_load,
  output logic [MW-1:0] mask_val,
  output logic          in_isr,
  output logic          stk_ovf,
  output logic          stk_unf
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] target_q, target_d;
  logic          in_isr_q, in_isr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          i_ack_c;
  logic          stk_push, stk_pop;
  logic [AW-1:0] stk_top;
  logic          stk_full, stk_empty;
  logic [4:0]    opcode;
  logic [2:0]    cond;
  logic [AW-1:0] operand;
  logic [AW-1:0] pc_inc;

  assign opcode  = ir_q[IW-1:IW-5];
  assign cond    = ir_q[2:0];
  assign operand = AW'(imem_data);
  assign pc_inc  = pc_q + AW'(1);

  assign imem_addr  = pc_q;
  assign stg0_instr = ir_q;
  assign in_isr     = in_isr_q;
  assign stk_ovf    = ovf_q;
  assign stk_unf    = unf_q;
  // The acknowledge is combinational, so hold it low while reset is asserted
  assign i_ack      = i_ack_c & clr;

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .clr   (clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_q),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-state, datapath updates and per-state output strobes
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    target_d   = target_q;
    in_isr_d   = in_isr_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    i_ack_c    = 1'b0;
    stg0_valid = 1'b0;
    mask_load  = 1'b0;
    mask_val   = '0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (i_pending && !in_isr_q) begin
          // Interrupt entry: save the not-yet-fetched PC and vector away
          i_ack_c  = 1'b1;
          in_isr_d = 1'b1;
          pc_d     = IRQ_VEC;
          if (stk_full) begin
            ovf_d = 1'b1;
          end else begin
            stk_push = 1'b1;
          end
        end else begin
          ir_d    = imem_data;
          pc_d    = pc_inc;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (opcode)
          OP_BRA, OP_JMP, OP_BSR: state_d = ST_OPER;
          OP_RTS, OP_RTI:         state_d = ST_RET;
          OP_LMSK:                state_d = ST_LMSK;
          default:                state_d = ST_ISSUE;
        endcase
      end

      ST_OPER: begin
        // Second word carries the target; PC moves past it either way
        target_d = operand;
        pc_d     = pc_inc;
        case (opcode)
          OP_JMP: begin
            pc_d    = operand;
            state_d = ST_FETCH;
          end
          OP_BSR:  state_d = ST_CALL;
          default: state_d = ST_BR_EVAL;
        endcase
      end

      ST_BR_EVAL: begin
        // Wait for stage 1 to drain so the flags reflect its last instruction
        if (stg1_ready) begin
          if (cond_true(cond, flags)) begin
            pc_d = target_q;
          end
          state_d = ST_FETCH;
        end
      end

      ST_CALL: begin
        if (stk_full) begin
          ovf_d = 1'b1;
        end else begin
          stk_push = 1'b1;
        end
        pc_d    = target_q;
        state_d = ST_FETCH;
      end

      ST_RET: begin
        if (stk_empty) begin
          unf_d = 1'b1;
        end else begin
          stk_pop = 1'b1;
          pc_d    = stk_top;
        end
        if (opcode == OP_RTI) begin
          in_isr_d = 1'b0;
        end
        state_d = ST_FETCH;
      end

      ST_LMSK: begin
        mask_load = 1'b1;
        mask_val  = ir_q[MW-1:0];
        state_d   = ST_FETCH;
      end

      ST_ISSUE: begin
        stg0_valid = 1'b1;
        if (stg1_ready) begin
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_VEC;
      ir_q     <= '0;
      target_q <= '0;
      in_isr_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      target_q <= target_d;
      in_isr_q <= in_isr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule

// File: tb/tb_stage0_seq.sv
// Bench for stage0_seq: directed scenarios followed by a random program,
// all checked against an instruction-level reference model of the sequencer.
module tb_stage0_seq;

  localparam int         DEPTH   = 4;
  localparam logic [7:0] IRQ_PC  = 8'hF0;
  localparam logic [4:0] OP_BRA  = 5'b00110;
  localparam logic [4:0] OP_JMP  = 5'b00111;
  localparam logic [4:0] OP_BSR  = 5'b10101;
  localparam logic [4:0] OP_RTS  = 5'b01000;
  localparam logic [4:0] OP_RTI  = 5'b01001;
  localparam logic [4:0] OP_LMSK = 5'b01110;
  localparam int         LIMIT   = 500;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [3:0] flags;
  logic       i_pending;
  logic       i_ack;
  logic       stg0_valid;
  logic [7:0] stg0_instr;
  logic       stg1_ready;
  logic       mask_load;
  logic [2:0] mask_val;
  logic       in_isr;
  logic       stk_ovf;
  logic       stk_unf;

  logic [7:0] mem [256];
  assign imem_data = mem[imem_addr];

  stage0_seq #(
    .AW(8), .IW(8), .DEPTH(DEPTH), .RESET_VEC(8'h00), .IRQ_VEC(IRQ_PC), .MW(3)
  ) dut (
    .clk(clk), .clr(clr), .imem_addr(imem_addr), .imem_data(imem_data),
    .flags(flags), .i_pending(i_pending), .i_ack(i_ack),
    .stg0_valid(stg0_valid), .stg0_instr(stg0_instr), .stg1_ready(stg1_ready),
    .mask_load(mask_load), .mask_val(mask_val), .in_isr(in_isr),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int fail_count  = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stack [$];
  bit         m_isr, m_ovf, m_unf;

  // Stimulus controls and the inputs chosen for the current cycle
  int         stall_left, ready_pct, irq_pct;
  bit         flags_fixed;
  logic [3:0] flags_val;
  bit         cur_rdy, cur_irq;
  logic [3:0] cur_fl;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Pick this cycle's inputs, drive them just after the edge, settle
  task automatic applyStimulus();
    if (stall_left > 0) begin
      cur_rdy = 1'b0;
      stall_left--;
    end else begin
      cur_rdy = ($urandom_range(99) < ready_pct);
    end
    cur_fl     = flags_fixed ? flags_val : 4'($urandom);
    cur_irq    = ($urandom_range(99) < irq_pct);
    stg1_ready = cur_rdy;
    flags      = cur_fl;
    i_pending  = cur_irq;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input logic [7:0] addr, input bit valid, input bit ack,
                              input bit mload, input logic [2:0] mval, input logic [7:0] instr);
    checkOutput("imem_addr", imem_addr, addr);
    checkOutput("stg0_valid", stg0_valid, valid);
    checkOutput("i_ack", i_ack, ack);
    checkOutput("mask_load", mask_load, mload);
    checkOutput("mask_val", mask_val, mval);
    checkOutput("in_isr", in_isr, m_isr);
    checkOutput("stk_ovf", stk_ovf, m_ovf);
    checkOutput("stk_unf", stk_unf, m_unf);
    if (valid) checkOutput("stg0_instr", stg0_instr, instr);
  endtask

  function automatic bit br_taken(input logic [2:0] c, input logic [3:0] f);
    bit sel;
    sel = f[c[2:1]];
    if (c == 3'd7) return 1'b1;
    return c[0] ? !sel : sel;
  endfunction

  task automatic m_push(input logic [7:0] v);
    if (m_stack.size() == DEPTH) m_ovf = 1'b1;
    else m_stack.push_back(v);
  endtask

  task automatic m_reset();
    m_pc = 8'h00;
    m_stack.delete();
    m_isr = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Run one instruction (or one interrupt entry) cycle by cycle
  task automatic exec_one();
    logic [7:0] p, p1, p2, w0, w1;
    logic [4:0] op;
    p  = m_pc;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    applyStimulus();
    expect_cycle(p, 1'b0, cur_irq && !m_isr, 1'b0, 3'd0, 8'd0);
    if (cur_irq && !m_isr) begin
      m_push(p);
      m_pc  = IRQ_PC;
      m_isr = 1'b1;
      next_cycle();
      return;
    end
    w0 = mem[p];
    op = w0[7:3];
    next_cycle();
    applyStimulus();
    expect_cycle(p1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    next_cycle();
    if (op == OP_BRA || op == OP_JMP || op == OP_BSR) begin
      applyStimulus();
      expect_cycle(p1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      w1 = mem[p1];
      next_cycle();
      if (op == OP_JMP) begin
        m_pc = w1;
      end else if (op == OP_BSR) begin
        applyStimulus();
        expect_cycle(p2, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        m_push(p2);
        m_pc = w1;
        next_cycle();
      end else begin
        m_pc = p2;
        for (int n = 0; n < LIMIT; n++) begin
          applyStimulus();
          expect_cycle(p2, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
          next_cycle();
          if (cur_rdy) begin
            if (br_taken(w0[2:0], cur_fl)) m_pc = w1;
            break;
          end
        end
      end
    end else if (op == OP_RTS || op == OP_RTI) begin
      applyStimulus();
      expect_cycle(p1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
      end else begin
        m_pc  = p1;
        m_unf = 1'b1;
      end
      if (op == OP_RTI) m_isr = 1'b0;
      next_cycle();
    end else if (op == OP_LMSK) begin
      applyStimulus();
      expect_cycle(p1, 1'b0, 1'b0, 1'b1, w0[2:0], 8'd0);
      m_pc = p1;
      next_cycle();
    end else begin
      m_pc = p1;
      for (int n = 0; n < LIMIT; n++) begin
        applyStimulus();
        expect_cycle(p1, 1'b1, 1'b0, 1'b0, 3'd0, w0);
        next_cycle();
        if (cur_rdy) break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] b;
    clr = 1'b0; stg1_ready = 1'b0; flags = 4'd0; i_pending = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h08;
    m_reset();
    stall_left = 0; ready_pct = 100; irq_pct = 0;
    flags_fixed = 1'b1; flags_val = 4'd0;

    // Reset state
    #12;
    checkOutput("rst_imem_addr", imem_addr, 8'h00);
    checkOutput("rst_stg0_valid", stg0_valid, 1'b0);
    checkOutput("rst_stg0_instr", stg0_instr, 8'h00);
    checkOutput("rst_i_ack", i_ack, 1'b0);
    checkOutput("rst_mask_load", mask_load, 1'b0);
    checkOutput("rst_mask_val", mask_val, 3'd0);
    checkOutput("rst_in_isr", in_isr, 1'b0);
    checkOutput("rst_stk_ovf", stk_ovf, 1'b0);
    checkOutput("rst_stk_unf", stk_unf, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;

    // Two plain instructions, stage 1 busy for the first three cycles
    stall_left = 3;
    exec_one();
    exec_one();

    // BRA on Z, taken then not taken, with stalls in branch evaluation
    mem[8'h02] = 8'h30; mem[8'h03] = 8'h20;
    flags_val = 4'b0001; stall_left = 5;
    exec_one();
    mem[8'h20] = 8'h30; mem[8'h21] = 8'h40;
    flags_val = 4'b0000; stall_left = 4;
    exec_one();

    // JMP to 0x10, BSR to 0x40, RTS back to 0x12
    mem[8'h22] = 8'h38; mem[8'h23] = 8'h10;
    mem[8'h10] = 8'hA8; mem[8'h11] = 8'h40;
    mem[8'h40] = 8'h40;
    repeat (3) exec_one();

    // Five nested calls overflow a four-entry stack; last jump still taken
    mem[8'h12] = 8'hA8; mem[8'h13] = 8'h50;
    mem[8'h50] = 8'hA8; mem[8'h51] = 8'h60;
    mem[8'h60] = 8'hA8; mem[8'h61] = 8'h70;
    mem[8'h70] = 8'hA8; mem[8'h71] = 8'h80;
    mem[8'h80] = 8'hA8; mem[8'h81] = 8'h90;
    repeat (5) exec_one();

    // Unwind four returns, then one more on the empty stack
    mem[8'h90] = 8'h40; mem[8'h72] = 8'h40; mem[8'h62] = 8'h40;
    mem[8'h52] = 8'h40; mem[8'h14] = 8'h40;
    repeat (5) exec_one();

    // Interrupt at 0x05, second request ignored, RTI returns
    mem[8'h15] = 8'h38; mem[8'h16] = 8'h05;
    exec_one();
    irq_pct = 100;
    exec_one();
    mem[8'hF0] = 8'h08; mem[8'hF1] = 8'h48;
    exec_one();
    exec_one();
    irq_pct = 0;
    exec_one();

    // LMSK 0x75 at 0x06
    mem[8'h06] = 8'h75;
    exec_one();

    // Reset while an instruction is being offered
    stall_left = 10;
    applyStimulus(); expect_cycle(8'h07, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0); next_cycle();
    applyStimulus(); expect_cycle(8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0); next_cycle();
    applyStimulus(); expect_cycle(8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08);
    #1;
    clr = 1'b0;
    #1;
    m_reset();
    checkOutput("midrst_stg0_valid", stg0_valid, 1'b0);
    checkOutput("midrst_imem_addr", imem_addr, 8'h00);
    checkOutput("midrst_stk_ovf", stk_ovf, 1'b0);
    checkOutput("midrst_stk_unf", stk_unf, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;
    stall_left = 0;

    // Random program with random handshake, flags and interrupts
    for (int a = 0; a < 256; a++) begin
      b = 8'($urandom);
      case ($urandom_range(9))
        0: b[7:3] = OP_BRA;
        1: b[7:3] = OP_JMP;
        2: b[7:3] = OP_BSR;
        3: b[7:3] = OP_RTS;
        4: b[7:3] = OP_RTI;
        5: b[7:3] = OP_LMSK;
        default: ;
      endcase
      mem[a] = b;
    end
    flags_fixed = 1'b0;
    ready_pct   = 60;
    irq_pct     = 4;
    repeat (400) exec_one();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/stage0_seq.md
Name: stage0_seq

Overview:
- Parametrised stage-0 fetch/branch sequencer for the accumulator processor. It owns the PC and fetches from instruction memory, and it executes flow-control opcodes locally: BRA, JMP, BSR, RTS, RTI and LMSK.
- All other instructions are handed to stage 1 over a valid/ready handshake.
- Compared with the previous sequencer it adds: parametrised widths, a full 8-way branch-condition set, a hardware return stack with overflow/underflow flags, and interrupt entry/exit with nesting lockout.

Parameters:
- AW, 8, PC / instruction-memory address width.
- IW, 8, instruction width; opcode = instr[IW-1:IW-5], cond = instr[2:0].
- DEPTH, 4, return-stack entries (power of 2, >= 2).
- RESET_VEC, 0, PC value after reset.
- IRQ_VEC, 8'hF0, PC loaded on interrupt entry (AW bits).
- MW, 3, interrupt mask width; mask = instr[MW-1:0].

Ports:
- clk, in, 1, clock (rising edge).
- clr, in, 1, asynchronous active-low reset.
- imem_addr, out, AW, instruction address, equal to PC at all times.
- imem_data, in, IW, combinational read data for imem_addr.
- flags, in, 4, {V,C,N,Z} from stage 1 CCR.
- i_pending, in, 1, interrupt request, level.
- i_ack, out, 1, one-cycle pulse on interrupt entry.
- stg0_valid, out, 1, instruction offered to stage 1.
- stg0_instr, out, IW, registered instruction (IR).
- stg1_ready, in, 1, stage 1 accepts / idle.
- mask_load, out, 1, one-cycle pulse on LMSK.
- mask_val, out, MW, mask value; valid while mask_load = 1.
- in_isr, out, 1, interrupt service active.
- stk_ovf, out, 1, sticky flag: push while full.
- stk_unf, out, 1, sticky flag: pop while empty.

Behaviour:
- Reset (async, clr = 0):
  - state = FETCH, PC = RESET_VEC, IR = 0, target = 0, SP = 0.
  - All 1-bit outputs = 0, mask_val = 0.
  - Reset mid-operation abandons any offered instruction; stage 1 sees stg0_valid fall immediately.
- States (encoded enum): FETCH, DECODE, OPER, ISSUE, BR_EVAL, CALL, RET, LMSK.
- FETCH:
  - If i_pending = 1 and in_isr = 0: push PC, PC <= IRQ_VEC, i_ack = 1 for this cycle, in_isr <= 1, stay in FETCH.
  - Otherwise: IR <= imem_data, PC <= PC+1, go to DECODE.
- DECODE, by opcode:
  - BRA (00110), JMP (00111), BSR (10101) -> OPER.
  - RTS (01000), RTI (01001) -> RET.
  - LMSK (01110) -> LMSK.
  - Any other opcode -> ISSUE.
- OPER: target <= imem_data (second instruction word, AW LSBs), PC <= PC+1. Next state: BRA -> BR_EVAL, JMP -> FETCH with PC <= target, BSR -> CALL.
- BR_EVAL:
  - Stall while stg1_ready = 0, because the instruction in stage 1 may still update flags.
  - When stg1_ready = 1, sample flags and evaluate cond:
    - 000 Z, 001 !Z
    - 010 N, 011 !N
    - 100 C, 101 !C
    - 110 V, 111 always
  - If the condition is true, PC <= target. Then go to FETCH.
- CALL:
  - Push PC (the return address), PC <= target, go to FETCH.
  - If the stack is full: no push, stk_ovf <= 1, and the jump is still taken.
- RET:
  - If the stack is non-empty: PC <= top, SP--.
  - If the stack is empty: PC unchanged, stk_unf <= 1.
  - RTI additionally clears in_isr. Go to FETCH.
- LMSK: mask_load = 1 and mask_val = IR[MW-1:0] for one cycle, go to FETCH.
- ISSUE:
  - stg0_valid = 1 and stg0_instr = IR, held stable until the transfer.
  - Transfer happens when stg0_valid and stg1_ready are both 1 in the same cycle; then go to FETCH.
  - stg0_valid is 0 in every other state.
- Latency:
  - Non-flow instruction: 2 cycles to stg0_valid.
  - JMP: 3 cycles to new fetch.
  - BRA: at least 4 cycles.
- Interrupts:
  - Sampled only in FETCH; the request is ignored while in_isr = 1 (no nesting).
  - The interrupt push obeys the same full rule as CALL.
- PC arithmetic: modulo 2^AW; wraps from all-ones to 0 without a flag.
- Sticky flags (stk_ovf, stk_unf) clear only on reset.

Decomposition:
- Package stage0_pkg holds: opcode constants, condition-code constants, and the state enum.
- Sub-module ret_stack (params AW, DEPTH):
  - Ports: push, pop, din, top, full, empty.
  - Simultaneous push and pop is never issued by stage0_seq; ret_stack asserts on it in simulation.

Test Plan:
- Reset with RESET_VEC = 0; memory: 0 = ADD, 1 = ADD; stg1_ready held 0 for 3 cycles -> imem_addr 0 then 1; stg0_valid high from cycle 2, stg0_instr stable; transfer on the first cycle stg1_ready = 1; next fetch at address 1.
- BRA cond 000 with target 8'h20, Z = 1 -> PC = 0x20; same with Z = 0 -> PC = 0x02; BR_EVAL stalls while stg1_ready = 0.
- BSR to 0x40 from address 0x10 then RTS -> PC = 0x12; with DEPTH = 4, five nested BSRs -> stk_ovf = 1, fifth jump still taken.
- RTS with empty stack -> stk_unf = 1, PC unchanged (continues sequentially).
- i_pending during FETCH at PC = 0x05 -> i_ack pulse, PC = 0xF0, in_isr = 1; second request ignored; RTI -> PC = 0x05, in_isr = 0.
- LMSK with instr 0x75 -> mask_load pulse, mask_val = 3'b101; clr pulsed low during ISSUE -> stg0_valid = 0 immediately, PC = RESET_VEC.
